// File: rtl/out_stream_buffer_pkg.sv
// Shared constants for the result-stream path from the processing core
// to the downstream consumer.
package out_stream_buffer_pkg;

    localparam int OSB_DATA_W = 14;
    localparam int OSB_DEPTH  = 16;

    typedef enum logic [1:0] {
        PUSH_NONE = 2'b00,
        PUSH_MID  = 2'b01,
        PUSH_LAST = 2'b11
    } push_kind_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy counter.
// Push and pop in the same cycle both take effect, even when full.
module sync_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LVL_FULL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/out_stream_buffer.sv
// Frames core result words: a one-word stage delays each push until the
// next word or the op-ready rising edge tells whether it is the last.
module out_stream_buffer
    import out_stream_buffer_pkg::*;
#(
    parameter int DATA_W = OSB_DATA_W,
    parameter int DEPTH  = OSB_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_out_valid,
    input  logic [DATA_W-1:0]        i_out_data,
    input  logic                     i_op_ready,
    output logic                     o_m_valid,
    output logic [DATA_W-1:0]        o_m_data,
    output logic                     o_m_last,
    input  logic                     i_m_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    logic              r_stage_v;
    logic [DATA_W-1:0] r_stage_d;
    logic              r_op_q;
    logic              r_armed;
    logic              r_overflow;
    logic              w_edge;
    push_kind_e        w_kind;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W:0]   w_rdata;

    // r_armed blocks a level that is already high at reset release
    // from looking like a fresh edge.
    assign w_edge = r_armed & i_op_ready & ~r_op_q;

    always_comb begin
        w_kind = PUSH_NONE;
        if (r_stage_v && w_edge) begin
            w_kind = PUSH_LAST;
        end else if (r_stage_v && i_out_valid) begin
            w_kind = PUSH_MID;
        end
    end

    assign w_push = (w_kind != PUSH_NONE);
    assign w_pop  = o_m_valid & i_m_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage_v  <= 1'b0;
            r_stage_d  <= '0;
            r_op_q     <= 1'b0;
            r_armed    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_op_q  <= i_op_ready;
            r_armed <= 1'b1;
            if (i_out_valid) begin
                r_stage_v <= 1'b1;
                r_stage_d <= i_out_data;
            end else if (w_edge) begin
                r_stage_v <= 1'b0;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata ({w_kind == PUSH_LAST, r_stage_d}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    assign o_m_valid  = ~w_empty;
    assign o_m_data   = w_rdata[DATA_W-1:0];
    assign o_m_last   = w_rdata[DATA_W];
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_out_stream_buffer.sv
// Randomized and directed checks of out_stream_buffer against a
// queue-based frame model.
module tb_out_stream_buffer;

    localparam int DW = 14;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ov = 1'b0;
    logic [DW-1:0] od = '0;
    logic          opr = 1'b0;
    logic          mr = 1'b0;
    logic          mv;
    logic [DW-1:0] md;
    logic          ml;
    logic [4:0]    lvl;
    logic          ovf;

    int total = 0;
    int bad = 0;

    logic [DW:0]   q[$];
    logic [DW:0]   got[$];
    bit            st_v;
    logic [DW-1:0] st_d;
    bit            prev_op;
    bit            m_ovf;

    always #5 clk = ~clk;

    out_stream_buffer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_out_valid (ov),
        .i_out_data  (od),
        .i_op_ready  (opr),
        .o_m_valid   (mv),
        .o_m_data    (md),
        .o_m_last    (ml),
        .i_m_ready   (mr),
        .o_level     (lvl),
        .o_overflow  (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // One clock: compare against model, drive, advance model on the edge.
    task automatic cyc(input bit v, input logic [DW-1:0] d,
                       input bit op, input bit r);
        bit edge_s, push, pop;
        logic [DW:0] pe;
        chk("level", 32'(lvl), 32'(q.size()));
        chk("valid", 32'(mv), 32'(q.size() != 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        ov = v; od = d; opr = op; mr = r;
        #1;
        if (q.size() != 0 && r) begin
            chk("data", 32'({ml, md}), 32'(q[0]));
            got.push_back(q[0]);
        end
        @(posedge clk);
        edge_s = op && !prev_op;
        prev_op = op;
        push = st_v && (edge_s || v);
        pe = {edge_s, st_d};
        if (v) begin
            st_v = 1; st_d = d;
        end else if (edge_s) begin
            st_v = 0;
        end
        pop = (q.size() != 0) && r;
        if (push && q.size() == DP && !pop) begin
            m_ovf = 1; push = 0;
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(pe);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit op);
        @(negedge clk);
        rst_n = 0; opr = op; ov = 0; mr = 0;
        #1;
        chk("rst_level", 32'(lvl), 32'd0);
        chk("rst_valid", 32'(mv), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        q.delete(); got.delete();
        st_v = 0; m_ovf = 0; prev_op = 1;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, 0, 1);
    endtask

    initial begin
        logic [DW-1:0] w[$];

        // Simple three-word frame
        do_reset(0);
        cyc(1, 14'h10, 0, 1);
        cyc(1, 14'h20, 0, 1);
        cyc(1, 14'h30, 0, 1);
        cyc(0, '0, 0, 1);
        cyc(0, '0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, '0, 1, 1);
        drain(2);
        chk("f_cnt", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("f_w0", 32'(got[0]), 32'h0010);
            chk("f_w1", 32'(got[1]), 32'h0020);
            chk("f_w2", 32'(got[2]), 32'h4030);
        end

        // Fill to full under backpressure, then overflow
        do_reset(0);
        w.delete();
        for (int i = 0; i < 16; i++) begin
            w.push_back(DW'(i * 7 + 3));
            cyc(1, w[i], 0, 0);
        end
        cyc(0, '0, 1, 0);
        chk("full_lvl", 32'(lvl), 32'd16);
        chk("full_ovf", 32'(ovf), 32'd0);
        cyc(0, '0, 0, 0);
        cyc(1, 14'h111, 0, 0);
        cyc(1, 14'h222, 0, 0);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_lvl", 32'(lvl), 32'd16);
        got.delete();
        drain(20);
        chk("bp_cnt", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk("bp_word", 32'(got[i]), 32'({i == 15, w[i]}));

        // Push and pop together at full
        do_reset(0);
        for (int i = 0; i < 16; i++) cyc(1, DW'(i), 0, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        cyc(1, 14'h3AB, 0, 0);
        cyc(1, 14'h3CD, 0, 1);
        chk("pp_lvl", 32'(lvl), 32'd16);
        chk("pp_ovf", 32'(ovf), 32'd0);
        drain(20);

        // Edge and new word in the same cycle
        do_reset(0);
        cyc(1, 14'h0AAA, 0, 0);
        cyc(1, 14'h0BBB, 1, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);
        drain(4);
        chk("se_cnt", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("se_a", 32'(got[0]), 32'h4AAA);
            chk("se_b", 32'(got[1]), 32'h4BBB);
        end

        // Operation with no output words
        do_reset(0);
        cyc(0, '0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, '0, 1, 1);
            chk("empty_op", 32'(mv), 32'd0);
        end

        // Reset in the middle of a frame
        do_reset(0);
        for (int i = 0; i < 6; i++) cyc(1, DW'(i + 50), 0, 0);
        chk("mid_lvl", 32'(lvl), 32'd5);
        do_reset(0);
        cyc(1, 14'h77, 0, 1);
        cyc(1, 14'h78, 0, 1);
        cyc(0, '0, 1, 1);
        drain(4);
        chk("rf_cnt", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("rf_w0", 32'(got[0]), 32'h0077);
            chk("rf_w1", 32'(got[1]), 32'h4078);
        end

        // op_ready high across reset release is not an edge
        do_reset(0);
        cyc(1, 14'h55, 1, 1);
        do_reset(1);
        cyc(1, 14'h66, 1, 1);
        cyc(0, '0, 1, 1);
        cyc(0, '0, 1, 1);
        chk("hold_lvl", 32'(lvl), 32'd0);
        cyc(0, '0, 0, 1);
        cyc(0, '0, 1, 1);
        drain(3);

        // Random traffic
        do_reset(0);
        for (int i = 0; i < 3000; i++) begin
            bit v, op, r;
            if ($urandom_range(0, 499) == 0) do_reset(bit'($urandom_range(0, 1)));
            v = ($urandom_range(0, 99) < 55);
            op = ($urandom_range(0, 99) < 20) ? ~prev_op : prev_op;
            r = ($urandom_range(0, 99) < ((i / 300) % 2 ? 30 : 80));
            cyc(v, DW'($urandom), op, r);
        end
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
